// File: rtl/secuenciador_fetch.sv
// secuenciador_fetch: byte-wide instruction fetch sequencer feeding
// opcode/operand pairs and branch resolution to the arquitectura datapath.
module secuenciador_fetch #(
  parameter int unsigned         ANCHO_PC     = 8,
  parameter logic [ANCHO_PC-1:0] VECTOR_RESET = '0
) (
  input  logic                clck,
  input  logic                rst_n,
  input  logic                ejecutar,
  output logic [ANCHO_PC-1:0] mem_addr,
  output logic                mem_req,
  input  logic                mem_ack,
  input  logic [7:0]          mem_dato,
  input  logic                ocupado,
  input  logic                flag,
  output logic [7:0]          instruccion,
  output logic [7:0]          datos,
  output logic                emite,
  output logic [ANCHO_PC-1:0] pc
);

  typedef enum logic [1:0] {
    REPOSO,
    BUSCA_OP,
    BUSCA_DAT,
    EMITE
  } estado_e;

  estado_e             estado_q, estado_d;
  logic [ANCHO_PC-1:0] pc_q, pc_d;
  logic [7:0]          instr_q, instr_d;
  logic [7:0]          datos_q, datos_d;

  // Loads and conditional branches carry an operand byte.
  function automatic logic es_doble(input logic [7:0] op);
    return (op[7:3] == 5'b10110) || (op[7:6] == 2'b11);
  endfunction

  logic es_salto;
  assign es_salto = (instr_q[7:6] == 2'b11) && flag;

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      pc_q     <= VECTOR_RESET;
      instr_q  <= '0;
      datos_q  <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      datos_q  <= datos_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    datos_d  = datos_q;
    unique case (estado_q)
      REPOSO: begin
        if (ejecutar) estado_d = BUSCA_OP;
      end
      BUSCA_OP: begin
        if (mem_ack) begin
          instr_d = mem_dato;
          pc_d    = pc_q + ANCHO_PC'(1);
          if (es_doble(mem_dato)) begin
            estado_d = BUSCA_DAT;
          end else begin
            datos_d  = '0;
            estado_d = EMITE;
          end
        end
      end
      BUSCA_DAT: begin
        if (mem_ack) begin
          datos_d  = mem_dato;
          pc_d     = pc_q + ANCHO_PC'(1);
          estado_d = EMITE;
        end
      end
      EMITE: begin
        if (!ocupado) begin
          if (es_salto) pc_d = ANCHO_PC'(datos_q);
          estado_d = ejecutar ? BUSCA_OP : REPOSO;
        end
      end
    endcase
  end

  // Address comes straight from pc, so it cannot move during wait states.
  assign mem_req     = (estado_q == BUSCA_OP) || (estado_q == BUSCA_DAT);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruccion = instr_q;
  assign datos       = datos_q;
  assign emite       = (estado_q == EMITE) && !ocupado;

endmodule

// File: tb/tb_secuenciador_fetch.sv
// tb_secuenciador_fetch: random stimulus against an
// instruction-stream reference model of the fetch sequencer.
module tb_secuenciador_fetch;

  logic       clck = 1'b0;
  logic       rst_n;
  logic       ejecutar;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_dato;
  logic       ocupado;
  logic       flag;
  logic [7:0] instruccion;
  logic [7:0] datos;
  logic       emite;
  logic [7:0] pc;

  always #5 clck = ~clck;

  secuenciador_fetch #(
    .ANCHO_PC(8),
    .VECTOR_RESET(8'h00)
  ) dut (
    .clck(clck),
    .rst_n(rst_n),
    .ejecutar(ejecutar),
    .mem_addr(mem_addr),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .mem_dato(mem_dato),
    .ocupado(ocupado),
    .flag(flag),
    .instruccion(instruccion),
    .datos(datos),
    .emite(emite),
    .pc(pc)
  );

  logic [7:0] mem [256];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic bit doble(input logic [7:0] op);
    return (op[7:3] == 5'b10110) || (op[7:6] == 2'b11);
  endfunction

  // Model: an engaged flag plus the bytes gathered for the current
  // instruction; an instruction is emitted once all its bytes arrived.
  bit         m_run;
  int         n_got;
  int         need;
  logic [7:0] b0, b1, m_pc, m_instr, m_datos, dato;
  logic       m_req, m_emit;
  int         n_emit = 0;

  task automatic model_reset();
    m_run   = 1'b0;
    n_got   = 0;
    b0      = '0;
    b1      = '0;
    m_pc    = 8'h00;
    m_instr = '0;
    m_datos = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h05;
    rst_n    = 1'b0;
    ejecutar = 1'b0;
    mem_ack  = 1'b0;
    mem_dato = '0;
    ocupado  = 1'b0;
    flag     = 1'b0;
    model_reset();

    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clck);
      need  = (n_got == 0) ? 1 : (doble(b0) ? 2 : 1);
      m_req = m_run && (n_got < need);

      rst_n    = !(cyc < 2 || $urandom_range(0, 299) == 0);
      ejecutar = (cyc < 40) ? 1'b1 : ($urandom_range(0, 9) != 0);
      ocupado  = (cyc < 40) ? 1'b0 : ($urandom_range(0, 2) == 0);
      flag     = 1'($urandom);
      if (m_req)
        mem_ack = (cyc < 40) ? 1'b1 : 1'($urandom);
      else
        mem_ack = ($urandom_range(0, 3) == 0);

      if (!rst_n) begin
        model_reset();
        need  = 1;
        m_req = 1'b0;
      end
      m_emit = m_run && (n_got >= need) && !ocupado;

      #1;
      mem_dato = mem_ack ? mem[mem_addr] : 8'($urandom);
      #1;
      check("mem_req", mem_req, m_req);
      if (m_req || !rst_n) check("mem_addr", mem_addr, m_pc);
      check("emite", emite, m_emit);
      check("instruccion", instruccion, m_instr);
      check("datos", datos, m_datos);
      check("pc", pc, m_pc);

      if (rst_n) begin
        if (!m_run) begin
          if (ejecutar) m_run = 1'b1;
        end else if (n_got < need) begin
          if (mem_ack) begin
            dato = mem[m_pc];
            if (n_got == 0) begin
              b0      = dato;
              m_instr = dato;
              if (!doble(dato)) m_datos = 8'h00;
            end else begin
              b1      = dato;
              m_datos = dato;
            end
            n_got++;
            m_pc = m_pc + 8'd1;
          end
        end else if (!ocupado) begin
          n_emit++;
          if (b0[7:6] == 2'b11 && flag) m_pc = b1;
          n_got = 0;
          m_run = ejecutar;
        end
      end
    end

    check("emit_count_nonzero", 32'(n_emit > 100), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
